// File: rtl/e_mdu.sv
// e_mdu: execute-stage multi-cycle multiply/divide unit with HI/LO registers.
// Optional divider: define MDU_DIV_EN to build div/divu; otherwise they act as no-ops.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  input  logic [3:0]  E_MDU_Op,
  output logic        E_MDU_Busy,
  output logic [31:0] E_MDU_Out,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [4:0] MUL_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N = 5'(DIV_CYCLES);

  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  op_q;
  logic [4:0]  cnt;
  logic        busy_r;

  logic        in_mul;
  logic        in_div;
  logic        in_start;
  logic        start;
  logic [4:0]  start_cnt;

  assign busy_r = (cnt != 5'd0);

  assign in_mul = (E_MDU_Op == OP_MULT) ||
                  (E_MDU_Op == OP_MULTU);
`ifdef MDU_DIV_EN
  assign in_div = (E_MDU_Op == OP_DIV) ||
                  (E_MDU_Op == OP_DIVU);
`else
  assign in_div = 1'b0;
`endif
  assign in_start  = in_mul | in_div;
  assign start     = in_start & ~busy_r;
  assign start_cnt = in_div ? DIV_N : MUL_N;

  assign E_MDU_Busy = busy_r | in_start;
  assign E_HI = hi;
  assign E_LO = lo;

  always_comb begin
    E_MDU_Out = 32'd0;
    if (E_MDU_Op == OP_MFHI)
      E_MDU_Out = hi;
    else if (E_MDU_Op == OP_MFLO)
      E_MDU_Out = lo;
  end

  // Sign-extend only for mult; multu zero-extends.
  logic        mul_sgn;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  assign mul_sgn = (op_q == OP_MULT);
  assign mul_a   = {{32{mul_sgn & a_q[31]}}, a_q};
  assign mul_b   = {{32{mul_sgn & b_q[31]}}, b_q};
  assign prod    = mul_a * mul_b;

  logic is_mul_q;
  logic is_div_q;
  logic [31:0] quo;
  logic [31:0] rem;

  assign is_mul_q = (op_q == OP_MULT) ||
                    (op_q == OP_MULTU);

`ifdef MDU_DIV_EN
  // Signed divide on magnitudes; 0x80000000/-1 wraps back to 0x80000000.
  logic        div_sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] uq;
  logic [31:0] ur;

  assign is_div_q = ((op_q == OP_DIV) ||
                     (op_q == OP_DIVU)) &&
                    (b_q != 32'd0);
  assign div_sgn = (op_q == OP_DIV);
  assign a_neg   = div_sgn & a_q[31];
  assign b_neg   = div_sgn & b_q[31];
  assign a_abs   = a_neg ? (32'd0 - a_q) : a_q;
  assign b_abs   = b_neg ? (32'd0 - b_q) : b_q;

  always_comb begin
    uq = 32'd0;
    ur = 32'd0;
    if (b_abs != 32'd0) begin
      uq = a_abs / b_abs;
      ur = a_abs % b_abs;
    end
  end

  assign quo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem = a_neg ? (32'd0 - ur) : ur;
`else
  assign is_div_q = 1'b0;
  assign quo      = 32'd0;
  assign rem      = 32'd0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      op_q <= 4'd0;
      cnt  <= 5'd0;
    end else if (start) begin
      a_q  <= E_RD1;
      b_q  <= E_RD2;
      op_q <= E_MDU_Op;
      cnt  <= start_cnt;
    end else if (cnt > 5'd1) begin
      cnt <= cnt - 5'd1;
    end else if (cnt == 5'd1) begin
      cnt <= 5'd0;
      unique case (1'b1)
        is_mul_q: begin
          hi <= prod[63:32];
          lo <= prod[31:0];
        end
        is_div_q: begin
          hi <= rem;
          lo <= quo;
        end
        default: ;
      endcase
    end else if (E_MDU_Op == OP_MTHI) begin
      hi <= E_RD1;
    end else if (E_MDU_Op == OP_MTLO) begin
      lo <= E_RD1;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed scoreboard bench for e_mdu.
// Expectations follow MDU_DIV_EN in the same way as the design build.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] E_RD1 = 32'd0;
  logic [31:0] E_RD2 = 32'd0;
  logic [3:0]  E_MDU_Op = 4'd0;
  logic        E_MDU_Busy;
  logic [31:0] E_MDU_Out;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  e_mdu #(.MULT_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk),
    .reset(reset),
    .E_RD1(E_RD1),
    .E_RD2(E_RD2),
    .E_MDU_Op(E_MDU_Op),
    .E_MDU_Busy(E_MDU_Busy),
    .E_MDU_Out(E_MDU_Out),
    .E_HI(E_HI),
    .E_LO(E_LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    logic        sbusy;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Drives one op for a single cycle; now=1 means already at a negedge.
  task automatic issue(input bit now,
                       input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output logic bsy,
                       output logic [31:0] out);
    if (!now) @(negedge clk);
    E_MDU_Op = op;
    E_RD1 = a;
    E_RD2 = b;
    #1;
    bsy = E_MDU_Busy;
    out = E_MDU_Out;
    @(posedge clk);
    #1;
    E_MDU_Op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!E_MDU_Busy) break;
      n++;
    end
  endtask

  // Independent reference for expected HI/LO.
  task automatic push_exp(input logic [3:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input int adj);
    exp_t e;
    longint sa;
    longint sb;
    logic [63:0] p;
    e.hi = cur_hi;
    e.lo = cur_lo;
    e.cyc = MUL_N;
    e.sbusy = 1'b1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin
        p = 64'(sa * sb);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      4'd2: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        e.cyc = DIV_ON ? DIV_N : 0;
        e.sbusy = DIV_ON;
        if (DIV_ON && b != 32'd0) begin
          if (op == 4'd3) begin
            e.lo = 32'(sa / sb);
            e.hi = 32'(sa % sb);
          end else begin
            e.lo = a / b;
            e.hi = a % b;
          end
        end
      end
    endcase
    if (e.cyc > 0) e.cyc = e.cyc - adj;
    cur_hi = e.hi;
    cur_lo = e.lo;
    exp_q.push_back(e);
  endtask

  task automatic finish_op(input string tag,
                           input logic sb);
    exp_t e;
    int n;
    wait_idle(n);
    e = exp_q.pop_front();
    chk({tag, "_startbusy"}, {31'd0, sb},
        {31'd0, e.sbusy});
    chk({tag, "_cycles"}, n, e.cyc);
    chk({tag, "_hi"}, E_HI, e.hi);
    chk({tag, "_lo"}, E_LO, e.lo);
  endtask

  task automatic run(input bit now,
                     input string tag,
                     input logic [3:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b);
    logic bsy;
    logic [31:0] out;
    push_exp(op, a, b, 0);
    issue(now, op, a, b, bsy, out);
    finish_op(tag, bsy);
  endtask

  initial begin
    logic bsy;
    logic [31:0] out;
    logic [31:0] ra;
    logic [31:0] rb;

    #12;
    chk("rst_busy", {31'd0, E_MDU_Busy}, 32'd0);
    chk("rst_hi", E_HI, 32'd0);
    chk("rst_lo", E_LO, 32'd0);
    chk("rst_out", E_MDU_Out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Abort a mult with reset at cnt=3.
    issue(0, 4'd7, 32'h55, 32'd0, bsy, out);
    issue(0, 4'd8, 32'h66, 32'd0, bsy, out);
    @(negedge clk);
    chk("mt_hi", E_HI, 32'h55);
    chk("mt_lo", E_LO, 32'h66);
    issue(1, 4'd1, 32'd3, 32'd4, bsy, out);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, E_MDU_Busy}, 32'd0);
    chk("abort_hi", E_HI, 32'd0);
    chk("abort_lo", E_LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_busy", {31'd0, E_MDU_Busy}, 32'd0);
    chk("post_hi", E_HI, 32'd0);
    chk("post_lo", E_LO, 32'd0);

    run(0, "mult_neg", 4'd1, 32'hFFFFFFFD, 32'd5);
    chk("mult_neg_hi_k", E_HI, 32'hFFFFFFFF);
    chk("mult_neg_lo_k", E_LO, 32'hFFFFFFF1);
    run(1, "multu", 4'd2, 32'hFFFFFFFF, 32'd2);
    chk("multu_hi_k", E_HI, 32'h00000001);
    chk("multu_lo_k", E_LO, 32'hFFFFFFFE);
    ra = $urandom;
    rb = $urandom;
    run(1, "multu_b2b", 4'd2, ra, rb);
    ra = $urandom;
    rb = $urandom;
    run(0, "mult_rnd", 4'd1, ra, rb);

    run(0, "div_neg", 4'd3, 32'hFFFFFFF9, 32'd2);
    if (DIV_ON) begin
      chk("div_neg_lo_k", E_LO, 32'hFFFFFFFD);
      chk("div_neg_hi_k", E_HI, 32'hFFFFFFFF);
    end
    run(0, "div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF);
    issue(0, 4'd7, 32'h11, 32'd0, bsy, out);
    issue(0, 4'd8, 32'h22, 32'd0, bsy, out);
    cur_hi = 32'h11;
    cur_lo = 32'h22;
    run(0, "div_zero", 4'd3, 32'd7, 32'd0);
    ra = $urandom;
    rb = $urandom_range(1, 1000);
    run(0, "divu_rnd", 4'd4, ra, rb);
    run(0, "inv_op", 4'd12, 32'd9, 32'd9);

    // mthi while busy must be dropped.
    push_exp(4'd1, 32'd6, 32'hFFFFFFFE, 1);
    issue(0, 4'd1, 32'd6, 32'hFFFFFFFE, bsy, out);
    issue(1'b0, 4'd7, 32'hABCD, 32'd0, bsy, out);
    chk("mthi_busy_flag", {31'd0, bsy}, 32'd1);
    finish_op("mthi_busy", 1'b1);

    issue(1, 4'd7, 32'hABCD, 32'd0, bsy, out);
    @(negedge clk);
    chk("mthi_hi", E_HI, 32'hABCD);
    issue(1, 4'd5, 32'd0, 32'd0, bsy, out);
    chk("mfhi_out", out, 32'hABCD);
    issue(0, 4'd6, 32'd0, 32'd0, bsy, out);
    chk("mflo_out", out, cur_lo);
    issue(0, 4'd0, 32'd0, 32'd0, bsy, out);
    chk("none_out", out, 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the five-stage pipeline. It consumes the operands and MDU opcode registered by the D→E pipeline register, performs multi-cycle signed and unsigned multiply and divide into the architectural HI/LO registers, and returns HI/LO for mfhi/mflo. It raises a busy flag that the hazard unit uses to stall the D stage.

## Interface
Parameters
- MULT_CYCLES, 5: cycles after the start edge until mult/multu results commit; legal range 1..31.
- DIV_CYCLES, 10: cycles after the start edge until div/divu results commit; legal range 1..31.

Ports
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately while low.
- E_RD1  in  32  rs operand (forwarded value).
- E_RD2  in  32  rt operand (forwarded value).
- E_MDU_Op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 are treated as none.
- E_MDU_Busy  out  1  high while an operation is starting or in progress.
- E_MDU_Out  out  32  HI for mfhi, LO for mflo, otherwise 0; combinational.
- E_HI  out  32  architectural HI register.
- E_LO  out  32  architectural LO register.

## Operation
- State: HI, LO, operand latches A/B, op latch, 5-bit down-counter cnt, and busy_r (busy_r = cnt≠0).
- Start: when E_MDU_Op ∈ {1..4} and busy_r=0:
  - Latch E_RD1/E_RD2 into A/B and the op into the op latch.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
- Countdown:
  - Each edge with cnt>1 decrements cnt.
  - The edge with cnt=1 writes HI/LO from A/B according to the op latch and sets cnt to 0.
- Arithmetic:
  - mult/multu: {HI,LO} = 64-bit signed/unsigned product.
  - div: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor B=0: the commit edge leaves HI/LO unchanged; busy timing is unaffected.
- mthi/mtlo:
  - With busy_r=0, the edge writes E_RD1 into HI/LO.
  - With busy_r=1, the op is ignored.
- Start ops presented while busy_r=1 are ignored. The hazard unit guarantees they do not occur; the rule still holds.
- E_MDU_Busy = busy_r | (E_MDU_Op ∈ {1..4}). The start cycle itself reports busy so that the following MDU instruction stalls in D.
- mfhi/mflo during busy return the pre-operation HI/LO; the hazard unit must stall them.
- Bubbles from D_E_clear arrive as op 0 and have no effect.

## Timing
- Reset (reset=0): HI=0, LO=0, cnt=0, busy_r=0, A=B=0, op latch=0. Consequently E_MDU_Busy=0 (if op 0), E_MDU_Out=0, E_HI=0, E_LO=0.
- Reset mid-operation aborts the operation; HI/LO read 0 after release.
- Start in cycle T (edge at end of T latches operands):
  - E_MDU_Busy is high in cycles T..T+N, where N is the cycle count for the op.
  - HI/LO take their new values at the edge ending cycle T+N.
  - E_MDU_Busy is low in cycle T+N+1.
  - mfhi in T+N+1 returns the new HI.
  - A back-to-back start in T+N+1 is accepted.
- Simultaneous commit and mthi at the commit edge: impossible, because busy_r=1 blocks the mthi. Result: commit wins.
- E_MDU_Out has zero latency: it is a combinational mux of current HI/LO.

## Configuration
- MDU_DIV_EN defined: div/divu are implemented as specified above.
- MDU_DIV_EN undefined:
  - Ops 3 and 4 behave as op 0: no busy, no counter load, HI/LO unchanged.
  - The divider logic is not synthesized; DIV_CYCLES is unused.

## Test plan
- Reset low mid-mult (cnt=3), then release → E_MDU_Busy=0, E_HI=E_LO=0, with no later commit.
- mult E_RD1=0xFFFFFFFD, E_RD2=5 at T → busy high T..T+5; E_HI=0xFFFFFFFF and E_LO=0xFFFFFFF1 from T+6.
- multu 0xFFFFFFFF×2 → HI=0x00000001, LO=0xFFFFFFFE. An immediate multu at T+6 is accepted.
- div 0xFFFFFFF9 / 2 (MDU_DIV_EN defined) → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Division by zero:
  - div 7/0 with prior HI=0x11, LO=0x22 → busy 11 cycles; HI/LO stay 0x11/0x22.
  - Without MDU_DIV_EN → busy never asserts.
- mthi 0xABCD issued during busy → ignored; mthi 0xABCD after busy drops → E_HI=0xABCD, and mfhi gives E_MDU_Out=0xABCD.
